hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_if.sv | 39 +++
 rtl/hazard_ctrl.sv | 106 ++++++++++
 2 files changed

// File: rtl/hazard_if.sv
// rtl/hazard_if.sv - pipeline <-> hazard unit signal bundle
// master = pipeline side, slave = hazard_ctrl side
interface hazard_if;
   logic [4:0] rsD;
   logic [4:0] rtD;
   logic [4:0] writeregE;
   logic       mem_read_enE;
   logic       reg_write_enE;
   logic       div_reqE;
   logic       mispredictE;
   logic       excM;
   logic       i_stall;
   logic       d_stall;
   logic       stallF;
   logic       stallD;
   logic       stallE;
   logic       stallM;
   logic       stallW;
   logic       flushD;
   logic       flushE;
   logic       flushM;
   logic       flushW;
   logic       div_busy;
   logic       div_done;

   modport master (
      output rsD, rtD, writeregE, mem_read_enE, reg_write_enE, div_reqE,
             mispredictE, excM, i_stall, d_stall,
      input  stallF, stallD, stallE, stallM, stallW,
             flushD, flushE, flushM, flushW, div_busy, div_done
   );

   modport slave (
      input  rsD, rtD, writeregE, mem_read_enE, reg_write_enE, div_reqE,
             mispredictE, excM, i_stall, d_stall,
      output stallF, stallD, stallE, stallM, stallW,
             flushD, flushE, flushM, flushW, div_busy, div_done
   );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush control with multi-cycle divider sequencing
// Priority: cache stall > exception > divider > load-use > mispredict.
module hazard_ctrl (
   input  logic    clk,
   input  logic    rst,
   hazard_if.slave hz
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

   div_state_t state_q;
   logic [5:0] cnt_q;
   logic       pend_exc_q;

   logic cache_stall;
   logic exc_eff;
   logic load_use;
   logic div_busy;
   logic stall_f, stall_d, stall_e, stall_m, stall_w;
   logic flush_d, flush_e, flush_m, flush_w;

   assign cache_stall = hz.i_stall | hz.d_stall;
   assign exc_eff     = (hz.excM | pend_exc_q) & ~cache_stall;
   assign load_use    = hz.mem_read_enE & hz.reg_write_enE & (hz.writeregE != 5'd0) &
                        ((hz.writeregE == hz.rsD) | (hz.writeregE == hz.rtD));
   assign div_busy    = (state_q == BUSY) | ((state_q == IDLE) & hz.div_reqE);

   // Counter runs 32..0 in BUSY, so a divide occupies 34 unstalled cycles including the request cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= 6'd0;
         pend_exc_q <= 1'b0;
      end else begin
         pend_exc_q <= cache_stall & (pend_exc_q | hz.excM);
         if (exc_eff) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
         end else begin
            case (state_q)
               IDLE: if (hz.div_reqE & ~cache_stall) begin
                  state_q <= BUSY;
                  cnt_q   <= 6'd32;
               end
               BUSY: if (~cache_stall) begin
                  if (cnt_q == 6'd0) state_q <= DONE;
                  else               cnt_q   <= cnt_q - 6'd1;
               end
               DONE:    state_q <= IDLE;
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   always_comb begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      stall_m = 1'b0;
      stall_w = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      flush_m = 1'b0;
      flush_w = 1'b0;
      if (!rst) begin
         if (cache_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            stall_w = 1'b1;
         end else if (exc_eff) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_m = 1'b1;
            flush_w = 1'b1;
         end else begin
            if (div_busy) begin
               stall_f = 1'b1;
               stall_d = 1'b1;
               stall_e = 1'b1;
               flush_m = 1'b1;
            end
            // A load-use bubble is not inserted into E while the divider holds it.
            if (load_use) begin
               stall_f = 1'b1;
               stall_d = 1'b1;
               flush_e = ~div_busy;
            end
            if (hz.mispredictE & ~div_busy & ~load_use) flush_d = 1'b1;
         end
      end
   end

   assign hz.stallF   = stall_f;
   assign hz.stallD   = stall_d;
   assign hz.stallE   = stall_e;
   assign hz.stallM   = stall_m;
   assign hz.stallW   = stall_w;
   assign hz.flushD   = flush_d;
   assign hz.flushE   = flush_e;
   assign hz.flushM   = flush_m;
   assign hz.flushW   = flush_w;
   assign hz.div_busy = div_busy & ~rst;
   assign hz.div_done = (state_q == DONE) & ~rst;
endmodule
